// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer among NUM_REQ byte producers.
// Issues registered tx_start/ack pulses, tracks tx_busy per frame and enforces an idle gap.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned GAP_CYCLES   = 16,
  parameter int unsigned BUSY_TIMEOUT = 8,
  localparam int unsigned OwnW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic [OwnW-1:0]        owner_o,
  output logic                   active_o,
  output logic                   tx_err_o,
  output logic                   tx_start_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_busy_i
);

  localparam int unsigned TW      = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam int unsigned GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GapLoad = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned ToLast  = BUSY_TIMEOUT - 1;

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone, StGap} state_e;

  state_e              state_q;
  logic [OwnW-1:0]     rr_q;
  logic [OwnW-1:0]     owner_q;
  logic [TW-1:0]       tout_q;
  logic [GW-1:0]       gap_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                active_q;
  logic                tx_err_q;
  logic                tx_start_q;
  logic [7:0]          tx_data_q;

  logic                gnt_valid;
  logic [OwnW-1:0]     gnt_idx;
  int unsigned         cand;

  // Search from rr_q+1 upward with wrap; the last winner is therefore checked last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(rr_q) + k) % NUM_REQ;
      if (!gnt_valid && req_i[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = OwnW'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_q       <= OwnW'(NUM_REQ - 1);
      owner_q    <= '0;
      tout_q     <= '0;
      gap_q      <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      active_q   <= 1'b0;
      tx_err_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      ack_q      <= '0;
      done_q     <= '0;
      tx_err_q   <= 1'b0;
      tx_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A busy line at idle belongs to someone else; hold off granting.
          if (gnt_valid && !tx_busy_i) begin
            tx_start_q <= 1'b1;
            ack_q      <= NUM_REQ'(1) << gnt_idx;
            tx_data_q  <= req_data_i[8*gnt_idx +: 8];
            owner_q    <= gnt_idx;
            rr_q       <= gnt_idx;
            active_q   <= 1'b1;
            tout_q     <= '0;
            state_q    <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          if (tx_busy_i) begin
            state_q <= StWaitDone;
          end else if (tout_q == TW'(ToLast)) begin
            tx_err_q <= 1'b1;
            active_q <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state_q <= StIdle;
            end else begin
              gap_q   <= GW'(GapLoad);
              state_q <= StGap;
            end
          end else begin
            tout_q <= tout_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!tx_busy_i) begin
            done_q   <= NUM_REQ'(1) << owner_q;
            active_q <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state_q <= StIdle;
            end else begin
              gap_q   <= GW'(GapLoad);
              state_q <= StGap;
            end
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign done_o     = done_q;
  assign owner_o    = owner_q;
  assign active_o   = active_q;
  assign tx_err_o   = tx_err_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single send, contention, wrap, timeout, busy-at-idle
// and mid-frame reset, with the serializer's tx_busy driven by hand.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic [1:0]  owner;
  logic        active;
  logic        tx_err;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n;
  int err_n;
  logic saw_done;

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .GAP_CYCLES   (16),
    .BUSY_TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .req_data_i (req_data),
    .ack_o      (ack),
    .done_o     (done),
    .owner_o    (owner),
    .active_o   (active),
    .tx_err_o   (tx_err),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .tx_busy_i  (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns the number of falling edges until tx_start is seen, or -1 if the bound expires.
  task automatic wait_start(input int limit, output int cnt);
    cnt = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (tx_start) begin
        cnt = i;
        break;
      end
    end
  endtask

  // Called in the tx_start cycle; returns in the cycle where done should be visible.
  task automatic run_frame(input int busy_len);
    @(negedge clk);
    tx_busy = 1'b1;
    repeat (busy_len) @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0;
    tx_busy  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack",      32'(ack),      32'h0);
    chk("rst_done",     32'(done),     32'h0);
    chk("rst_owner",    32'(owner),    32'h0);
    chk("rst_active",   32'(active),   32'h0);
    chk("rst_tx_err",   32'(tx_err),   32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_tx_data",  32'(tx_data),  32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_start", 32'(tx_start), 32'h0);

    // Single request
    req = 4'b0001;
    req_data[7:0] = 8'hA5;
    wait_start(5, n);
    chk("single_latency", n,              1);
    chk("single_ack",     32'(ack),       32'h1);
    chk("single_data",    32'(tx_data),   32'hA5);
    chk("single_owner",   32'(owner),     32'h0);
    chk("single_active",  32'(active),    32'h1);
    req = 4'b0000;
    req_data[7:0] = 8'hFF;
    run_frame(30);
    chk("single_done",    32'(done),      32'h1);
    chk("single_inactive",32'(active),    32'h0);
    chk("single_hold",    32'(tx_data),   32'hA5);
    chk("single_ack_low", 32'(ack),       32'h0);
    req = 4'b0001;
    req_data[7:0] = 8'h5A;
    wait_start(40, n);
    chk("gap_latency",    n,              17);
    chk("gap_data",       32'(tx_data),   32'h5A);
    req = 4'b0000;
    run_frame(4);
    chk("gap_done",       32'(done),      32'h1);
    repeat (20) @(negedge clk);

    // Reset restores priority to requester 0 for the contention run
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_owner",     32'(owner),     32'h0);
    chk("rst2_data",      32'(tx_data),   32'h0);

    // Contention: all four requesting
    req      = 4'b1111;
    req_data = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      wait_start(40, n);
      chk("cont_latency", n, (k == 0) ? 1 : 17);
      chk("cont_data",    32'(tx_data), 32'h11 * ((k % 4) + 1));
      chk("cont_owner",   32'(owner),   k % 4);
      chk("cont_ack",     32'(ack),     1 << (k % 4));
      if (k == 4) req = 4'b0000;
      run_frame(3);
      chk("cont_done",    32'(done),    1 << (k % 4));
    end
    repeat (20) @(negedge clk);

    // Wrap: after a grant to 2, requests 0 and 2 go to 0 first
    req = 4'b0100;
    req_data = 32'h0;
    wait_start(5, n);
    chk("wrap_first",     32'(owner), 32'h2);
    req = 4'b0101;
    run_frame(2);
    wait_start(40, n);
    chk("wrap_lat",       n,          17);
    chk("wrap_owner0",    32'(owner), 32'h0);
    run_frame(2);
    wait_start(40, n);
    chk("wrap_owner2",    32'(owner), 32'h2);
    req = 4'b0000;
    run_frame(2);
    repeat (20) @(negedge clk);

    // Timeout: tx_busy never rises
    req = 4'b0010;
    req_data[15:8] = 8'h77;
    wait_start(5, n);
    chk("to_latency",     n,          1);
    chk("to_owner",       32'(owner), 32'h1);
    err_n    = -1;
    saw_done = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done != 4'b0000) saw_done = 1'b1;
      if (tx_err) begin
        err_n = i;
        break;
      end
    end
    chk("to_err_delay",   err_n,           8);
    chk("to_active",      32'(active),     32'h0);
    chk("to_no_done",     32'(saw_done),   32'h0);
    @(negedge clk);
    chk("to_err_pulse",   32'(tx_err),     32'h0);
    wait_start(40, n);
    chk("to_regrant",     n,               16);
    chk("to_regrant_own", 32'(owner),      32'h1);
    chk("to_regrant_dat", 32'(tx_data),    32'h77);
    req = 4'b0000;
    run_frame(2);
    chk("to_done",        32'(done),       32'h2);
    repeat (20) @(negedge clk);

    // Busy line while idle blocks the grant
    tx_busy = 1'b1;
    req = 4'b0001;
    req_data[7:0] = 8'h3C;
    wait_start(6, n);
    chk("busy_idle_hold", n, -1);
    tx_busy = 1'b0;
    wait_start(5, n);
    chk("busy_idle_lat",  n,              1);
    chk("busy_idle_data", 32'(tx_data),   32'h3C);
    req = 4'b0000;
    run_frame(2);
    repeat (20) @(negedge clk);

    // Reset during WAIT_DONE
    req = 4'b0100;
    req_data[23:16] = 8'hC3;
    wait_start(5, n);
    chk("mid_owner",      32'(owner),     32'h2);
    req = 4'b1000;
    req_data[31:24] = 8'h99;
    @(negedge clk);
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_active",     32'(active),    32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_active", 32'(active),    32'h0);
    chk("mid_rst_owner",  32'(owner),     32'h0);
    chk("mid_rst_data",   32'(tx_data),   32'h0);
    chk("mid_rst_done",   32'(done),      32'h0);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("mid_no_done",    32'(done),      32'h0);
    rst = 1'b0;
    wait_start(5, n);
    chk("mid_regrant",    n,              1);
    chk("mid_owner3",     32'(owner),     32'h3);
    chk("mid_ack3",       32'(ack),       32'h8);
    chk("mid_data3",      32'(tx_data),   32'h99);
    req = 4'b0000;
    run_frame(2);
    chk("mid_done3",      32'(done),      32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
